// File: rtl/bsa_pkg.sv
// Shared constants and types for barrel_shift_arbiter: widths, op codes,
// requester IDs, FSM states and the latched command record.
package bsa_pkg;

    localparam int DATA_W  = 4;
    localparam int SHAMT_W = 2;
    localparam int OP_W    = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_ROL = 3'b010;
    localparam logic [OP_W-1:0] OP_ROR = 3'b011;
    localparam logic [OP_W-1:0] OP_SRA = 3'b100;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  data;
        logic               id;
    } cmd_t;

endpackage

// File: rtl/barrel_shift4.sv
// Combinational 4-bit shifter: shift-by-1 stage followed by shift-by-2 stage.
// Defining BSA_ARITH_EN adds op 100 (SRA); otherwise op 100 is reported illegal.
module barrel_shift4
    import bsa_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  result,
    output logic               err
);

    logic [DATA_W-1:0] stage1_s;
    logic [DATA_W-1:0] stage2_s;

    // Op legality decode
    always_comb begin
        err = 1'b1;
        case (op)
            OP_SLL:  err = 1'b0;
            OP_SRL:  err = 1'b0;
            OP_ROL:  err = 1'b0;
            OP_ROR:  err = 1'b0;
`ifdef BSA_ARITH_EN
            OP_SRA:  err = 1'b0;
`endif
            default: err = 1'b1;
        endcase
    end

    // Stage 1: shift by one position when shamt[0] is set
    always_comb begin
        stage1_s = data;
        if (shamt[0]) begin
            case (op)
                OP_SLL:  stage1_s = {data[2:0], 1'b0};
                OP_SRL:  stage1_s = {1'b0, data[3:1]};
                OP_ROL:  stage1_s = {data[2:0], data[3]};
                OP_ROR:  stage1_s = {data[0], data[3:1]};
`ifdef BSA_ARITH_EN
                OP_SRA:  stage1_s = {data[3], data[3:1]};
`endif
                default: stage1_s = 4'b0000;
            endcase
        end else begin
            stage1_s = data;
        end
    end

    // Stage 2: shift by two positions when shamt[1] is set; sign bit survives stage 1
    always_comb begin
        stage2_s = stage1_s;
        if (shamt[1]) begin
            case (op)
                OP_SLL:  stage2_s = {stage1_s[1:0], 2'b00};
                OP_SRL:  stage2_s = {2'b00, stage1_s[3:2]};
                OP_ROL:  stage2_s = {stage1_s[1:0], stage1_s[3:2]};
                OP_ROR:  stage2_s = {stage1_s[1:0], stage1_s[3:2]};
`ifdef BSA_ARITH_EN
                OP_SRA:  stage2_s = {{2{stage1_s[3]}}, stage1_s[3:2]};
`endif
                default: stage2_s = 4'b0000;
            endcase
        end else begin
            stage2_s = stage1_s;
        end
    end

    // Illegal ops always yield a zero result
    always_comb begin
        if (err) begin
            result = 4'b0000;
        end else begin
            result = stage2_s;
        end
    end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shift4 between requesters A and B,
// with an IDLE/EXEC/HOLD sequencer and a registered, ID-tagged result port.
// Optional SRA support is enabled by defining BSA_ARITH_EN.
module barrel_shift_arbiter
    import bsa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [OP_W-1:0]    a_op,
    input  logic [SHAMT_W-1:0] a_shamt,
    input  logic [DATA_W-1:0]  a_data,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [OP_W-1:0]    b_op,
    input  logic [SHAMT_W-1:0] b_shamt,
    input  logic [DATA_W-1:0]  b_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_id,
    output logic               out_err,
    output logic               busy
);

    state_e            state_r;
    state_e            state_next_s;
    logic              last_grant_r;
    cmd_t              cmd_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_id_r;
    logic              out_err_r;

    logic              grant_a_s;
    logic              grant_b_s;
    logic              a_ready_s;
    logic              b_ready_s;
    logic              out_valid_s;
    logic              busy_s;
    logic              accept_s;
    logic [DATA_W-1:0] shift_result_s;
    logic              shift_err_s;

    barrel_shift4 u_shift (
        .op     (cmd_r.op),
        .shamt  (cmd_r.shamt),
        .data   (cmd_r.data),
        .result (shift_result_s),
        .err    (shift_err_s)
    );

    // Round-robin pick: on a tie the requester not granted last time wins
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (a_valid && b_valid) begin
            if (last_grant_r == ID_B) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (a_valid) begin
            grant_a_s = 1'b1;
        end else if (b_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign accept_s = (a_ready_s && a_valid) || (b_ready_s && b_valid);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is also masked by rst so nothing is offered during reset
    always_comb begin
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                a_ready_s = grant_a_s && !rst;
                b_ready_s = grant_b_s && !rst;
            end
            ST_EXEC: busy_s = 1'b1;
            ST_HOLD: begin
                busy_s      = 1'b1;
                out_valid_s = 1'b1;
            end
            default: begin
                busy_s      = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Command latch and grant history, updated only on an accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= ID_B;
            cmd_r.op     <= 3'b000;
            cmd_r.shamt  <= 2'b00;
            cmd_r.data   <= 4'b0000;
            cmd_r.id     <= ID_A;
        end else if (accept_s) begin
            if (grant_b_s) begin
                last_grant_r <= ID_B;
                cmd_r.op     <= b_op;
                cmd_r.shamt  <= b_shamt;
                cmd_r.data   <= b_data;
                cmd_r.id     <= ID_B;
            end else begin
                last_grant_r <= ID_A;
                cmd_r.op     <= a_op;
                cmd_r.shamt  <= a_shamt;
                cmd_r.data   <= a_data;
                cmd_r.id     <= ID_A;
            end
        end else begin
            last_grant_r <= last_grant_r;
            cmd_r        <= cmd_r;
        end
    end

    // Result register, loaded in EXEC and frozen through HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r <= 4'b0000;
            out_id_r   <= 1'b0;
            out_err_r  <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            out_data_r <= shift_result_s;
            out_id_r   <= cmd_r.id;
            out_err_r  <= shift_err_s;
        end else begin
            out_data_r <= out_data_r;
            out_id_r   <= out_id_r;
            out_err_r  <= out_err_r;
        end
    end

    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign out_valid = out_valid_s;
    assign busy      = busy_s;
    assign out_data  = out_data_r;
    assign out_id    = out_id_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed self-checking bench for barrel_shift_arbiter.
// Build with BSA_ARITH_EN defined to expect SRA behaviour for op 100.
module tb_barrel_shift_arbiter;

    localparam logic [2:0] T_SLL = 3'b000;
    localparam logic [2:0] T_SRL = 3'b001;
    localparam logic [2:0] T_ROL = 3'b010;
    localparam logic [2:0] T_ROR = 3'b011;
    localparam logic [2:0] T_SRA = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [2:0] a_op, b_op;
    logic [1:0] a_shamt, b_shamt;
    logic [3:0] a_data, b_data;
    logic       out_valid, out_ready, out_id, out_err, busy;
    logic [3:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         req;
        logic [2:0] op;
        logic [1:0] sh;
        logic [3:0] d;
        logic [3:0] exp_d;
        logic       exp_err;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    barrel_shift_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_shamt(a_shamt), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_shamt(b_shamt), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_err(out_err), .busy(busy)
    );

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input bit req, input logic [2:0] op, input logic [1:0] sh, input logic [3:0] d);
        if (req == 1'b0) begin
            a_valid = 1'b1; a_op = op; a_shamt = sh; a_data = d;
        end else begin
            b_valid = 1'b1; b_op = op; b_shamt = sh; b_data = d;
        end
    endtask

    // Waits (bounded) for the requester's ready, then lets the accept edge pass
    task automatic wait_accept(input bit req, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if ((req == 1'b0 && a_ready) || (req == 1'b1 && b_ready)) begin
                ok = 1'b1;
                @(posedge clk); #1;
                if (req == 1'b0) a_valid = 1'b0; else b_valid = 1'b0;
                break;
            end
        end
    endtask

    // Counts falling edges after the accept edge until out_valid is seen
    task automatic wait_result(output bit ok, output int lat);
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_op = T_SLL; a_shamt = 2'd0; a_data = 4'h0; b_op = T_SLL; b_shamt = 2'd0; b_data = 4'h0;
        @(negedge clk); #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL reset_out_data: got %b expected 0000", out_data); end
        n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL reset_out_id: got %b expected 0", out_id); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok; int lat;
        do_reset();
        drive(1'b0, T_SLL, 2'd1, 4'b1011);
        wait_accept(1'b0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", ok); end
        @(negedge clk); #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_pulse: got %b expected 0", a_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_exec: got %b expected 1", busy); end
        wait_result(ok, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1 more edge (N+2)", lat); end
        n_checks++; if (out_data !== 4'b0110) begin n_fail++; $display("FAIL single_data: got %b expected 0110", out_data); end
        n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %b expected 0", out_id); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", out_err); end
    endtask

    task automatic test_shift_ops();
        bit ok; int lat;
        vecs[0]  = '{1'b0, T_ROR, 2'd1, 4'b1001, 4'b1100, 1'b0};
        vecs[1]  = '{1'b0, T_ROL, 2'd3, 4'b0001, 4'b1000, 1'b0};
        vecs[2]  = '{1'b0, T_SRL, 2'd2, 4'b1100, 4'b0011, 1'b0};
        vecs[3]  = '{1'b1, T_ROR, 2'd0, 4'b1011, 4'b1011, 1'b0};
        vecs[4]  = '{1'b0, T_SLL, 2'd3, 4'b0111, 4'b1000, 1'b0};
        vecs[5]  = '{1'b1, T_ROR, 2'd2, 4'b0110, 4'b1001, 1'b0};
        vecs[6]  = '{1'b1, T_ROL, 2'd1, 4'b1000, 4'b0001, 1'b0};
        vecs[7]  = '{1'b1, T_SRL, 2'd3, 4'b1000, 4'b0001, 1'b0};
        vecs[8]  = '{1'b1, 3'b111, 2'd1, 4'b1111, 4'b0000, 1'b1};
        vecs[9]  = '{1'b0, 3'b101, 2'd0, 4'b0110, 4'b0000, 1'b1};
        vecs[10] = '{1'b1, 3'b110, 2'd3, 4'b1010, 4'b0000, 1'b1};
`ifdef BSA_ARITH_EN
        vecs[11] = '{1'b1, T_SRA, 2'd2, 4'b1000, 4'b1110, 1'b0};
        vecs[12] = '{1'b0, T_SRA, 2'd1, 4'b0110, 4'b0011, 1'b0};
        vecs[13] = '{1'b0, T_SRA, 2'd0, 4'b1010, 4'b1010, 1'b0};
`else
        vecs[11] = '{1'b1, T_SRA, 2'd2, 4'b1000, 4'b0000, 1'b1};
        vecs[12] = '{1'b0, T_SRA, 2'd1, 4'b0110, 4'b0000, 1'b1};
        vecs[13] = '{1'b0, T_SRA, 2'd0, 4'b1010, 4'b0000, 1'b1};
`endif
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].req, vecs[i].op, vecs[i].sh, vecs[i].d);
            wait_accept(vecs[i].req, ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL vec%0d_accept: got %b expected 1", i, ok); end
            wait_result(ok, lat);
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 2", i, lat); end
            n_checks++; if (out_data !== vecs[i].exp_d) begin n_fail++; $display("FAIL vec%0d_data: got %b expected %b", i, out_data, vecs[i].exp_d); end
            n_checks++; if (out_err !== vecs[i].exp_err) begin n_fail++; $display("FAIL vec%0d_err: got %b expected %b", i, out_err, vecs[i].exp_err); end
            n_checks++; if (out_id !== vecs[i].req) begin n_fail++; $display("FAIL vec%0d_id: got %b expected %b", i, out_id, vecs[i].req); end
        end
    endtask

    task automatic test_tie();
        int grants[$]; int gtime[$]; int ids[$]; logic [3:0] datas[$];
        int both = 0;
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, T_SLL, 2'd1, 4'b0011);
        drive(1'b1, T_ROR, 2'd1, 4'b0011);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 13; cyc++) begin
            #1;
            if (a_ready && b_ready) both++;
            if (a_ready) begin grants.push_back(0); gtime.push_back(cyc); end
            else if (b_ready) begin grants.push_back(1); gtime.push_back(cyc); end
            if (out_valid && out_ready) begin ids.push_back(int'(out_id)); datas.push_back(out_data); end
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL tie_both_ready: got %0d cycles expected 0", both); end
        n_checks++; if (grants.size() !== 5) begin n_fail++; $display("FAIL tie_grant_count: got %0d expected 5", grants.size()); end
        n_checks++; if (ids.size() !== 4) begin n_fail++; $display("FAIL tie_result_count: got %0d expected 4", ids.size()); end
        for (int i = 0; i < grants.size() && i < 5; i++) begin
            n_checks++; if (grants[i] !== i % 2) begin n_fail++; $display("FAIL tie_grant%0d: got %0d expected %0d", i, grants[i], i % 2); end
            n_checks++; if (gtime[i] !== 3 * i) begin n_fail++; $display("FAIL tie_grant%0d_cycle: got %0d expected %0d", i, gtime[i], 3 * i); end
        end
        for (int i = 0; i < ids.size() && i < 4; i++) begin
            n_checks++; if (ids[i] !== i % 2) begin n_fail++; $display("FAIL tie_id%0d: got %0d expected %0d", i, ids[i], i % 2); end
            n_checks++; if (datas[i] !== ((i % 2 == 0) ? 4'b0110 : 4'b1001)) begin
                n_fail++; $display("FAIL tie_data%0d: got %b expected %b", i, datas[i], (i % 2 == 0) ? 4'b0110 : 4'b1001);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int lat;
        do_reset();
        out_ready = 1'b0;
        drive(1'b0, T_ROL, 2'd1, 4'b0110);
        wait_accept(1'b0, ok);
        wait_result(ok, lat);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise: got %b expected 1", ok); end
        drive(1'b1, T_SRL, 2'd1, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, out_valid); end
            n_checks++; if (out_data !== 4'b1100) begin n_fail++; $display("FAIL bp_hold_data%0d: got %b expected 1100", i, out_data); end
            n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold_id%0d: got %b expected 0", i, out_id); end
            n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_bready%0d: got %b expected 0", i, b_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got %b expected 1", b_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        wait_result(ok, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_b_latency: got %0d expected 2", lat); end
        n_checks++; if (out_data !== 4'b0100) begin n_fail++; $display("FAIL bp_b_data: got %b expected 0100", out_data); end
        n_checks++; if (out_id !== 1'b1) begin n_fail++; $display("FAIL bp_b_id: got %b expected 1", out_id); end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat;
        do_reset();
        out_ready = 1'b0;
        drive(1'b0, T_SLL, 2'd1, 4'b0001);
        wait_accept(1'b0, ok);
        wait_result(ok, lat);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_in_hold: got %b expected 1", out_valid); end
        drive(1'b0, T_ROL, 2'd2, 4'b0001);
        drive(1'b1, T_SRL, 2'd1, 4'b1000);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_a_ready: got %b expected 0", a_ready); end
        n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL mid_out_data: got %b expected 0000", out_data); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_tie_a_ready: got %b expected 1", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie_b_ready: got %b expected 0", b_ready); end
        b_valid = 1'b0;
        out_ready = 1'b1;
        wait_accept(1'b0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_post_accept: got %b expected 1", ok); end
        wait_result(ok, lat);
        n_checks++; if (out_data !== 4'b0100) begin n_fail++; $display("FAIL mid_post_data: got %b expected 0100", out_data); end
        n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL mid_post_id: got %b expected 0", out_id); end
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b expected 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_shift_ops();
        test_tie();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
